// File: rtl/alu_acc_sequencer_if.sv
// Command/result handshake bundle between a command source and alu_acc_sequencer.
// The master issues commands and consumes results; the slave is the sequencer.
interface alu_acc_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_type;
  logic [3:0] cmd_sel;
  logic       cmd_ci;
  logic [1:0] cmd_src;
  logic [1:0] cmd_dst;
  logic [3:0] cmd_imm;
  logic [1:0] cmd_cnt;
  logic       res_valid;
  logic       res_ready;
  logic [3:0] res_data;
  logic [2:0] res_flags;

  modport master (
    output cmd_valid, cmd_type, cmd_sel, cmd_ci, cmd_src, cmd_dst, cmd_imm, cmd_cnt,
    output res_ready,
    input  cmd_ready, res_valid, res_data, res_flags
  );

  modport slave (
    input  cmd_valid, cmd_type, cmd_sel, cmd_ci, cmd_src, cmd_dst, cmd_imm, cmd_cnt,
    input  res_ready,
    output cmd_ready, res_valid, res_data, res_flags
  );
endinterface

// File: rtl/alu_acc_sequencer.sv
// Accumulator/register/flag stage feeding an external combinational 4-bit ALU,
// with repeated ALU execution and a backpressured result handshake.
module alu_acc_sequencer #(
  parameter int unsigned NREG = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  alu_acc_sequencer_if.slave    bus,
  output logic [3:0]            alu_sel,
  output logic [3:0]            alu_a,
  output logic [3:0]            alu_b,
  output logic                  alu_ci,
  output logic                  alu_ir,
  output logic                  alu_il,
  input  logic [3:0]            alu_f,
  input  logic                  alu_co
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  typedef enum logic [1:0] {CMD_ALU = 2'b00, CMD_LDR = 2'b01, CMD_LDA = 2'b10, CMD_STA = 2'b11} cmd_t;

  state_t     state, state_nxt;
  cmd_t       type_q;
  logic [3:0] ac;
  logic [3:0] regs [NREG];
  logic       c, z, n;
  logic [1:0] src_q;
  logic [1:0] cnt_q;
  logic [3:0] imm_q;
  logic       accept;
  logic       c_nxt;

  assign accept = bus.cmd_valid && (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (cmd_t'(bus.cmd_type) == CMD_ALU) ? EXEC : DONE;
      EXEC: if (cnt_q == 2'd0) state_nxt = DONE;
      DONE: if (bus.res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Carry source depends on the ALU function class; shifts take the bit shifted out.
  always_comb begin
    c_nxt = 1'b0;
    case (alu_sel[3:2])
      2'b00: c_nxt = alu_co;
      2'b01: c_nxt = 1'b0;
      2'b10: c_nxt = ac[0];
      2'b11: c_nxt = ac[3];
      default: c_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ac      <= '0;
      c       <= 1'b0;
      z       <= 1'b0;
      n       <= 1'b0;
      alu_sel <= '0;
      alu_ci  <= 1'b0;
      src_q   <= '0;
      cnt_q   <= '0;
      imm_q   <= '0;
      type_q  <= CMD_ALU;
      for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (accept) begin
      type_q  <= cmd_t'(bus.cmd_type);
      alu_sel <= bus.cmd_sel;
      alu_ci  <= bus.cmd_ci;
      src_q   <= bus.cmd_src;
      cnt_q   <= bus.cmd_cnt;
      imm_q   <= bus.cmd_imm;
      case (cmd_t'(bus.cmd_type))
        CMD_LDR: regs[bus.cmd_dst] <= bus.cmd_imm;
        CMD_LDA: ac                <= regs[bus.cmd_src];
        CMD_STA: regs[bus.cmd_dst] <= ac;
        default: ;
      endcase
    end else if (state == EXEC) begin
      ac <= alu_f;
      c  <= c_nxt;
      z  <= (alu_f == 4'd0);
      n  <= alu_f[3];
      if (cnt_q != 2'd0) cnt_q <= cnt_q - 2'd1;
    end
  end

  assign alu_a  = ac;
  assign alu_b  = regs[src_q];
  assign alu_ir = c;
  assign alu_il = c;

  assign bus.cmd_ready = (state == IDLE);
  assign bus.res_valid = (state == DONE);
  assign bus.res_data  = (type_q == CMD_LDR) ? imm_q : ac;
  assign bus.res_flags = {c, z, n};

endmodule

// File: tb/tb_alu_acc_sequencer.sv
// Directed bench for alu_acc_sequencer: a reference 4-bit ALU closes the loop,
// a vector table covers single commands, hand sequences cover multi-cycle cases.
module tb_alu_acc_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] alu_sel, alu_a, alu_b, alu_f;
  logic       alu_ci, alu_ir, alu_il, alu_co;

  alu_acc_sequencer_if bus ();

  alu_acc_sequencer #(.NREG(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus.slave),
    .alu_sel(alu_sel),
    .alu_a  (alu_a),
    .alu_b  (alu_b),
    .alu_ci (alu_ci),
    .alu_ir (alu_ir),
    .alu_il (alu_il),
    .alu_f  (alu_f),
    .alu_co (alu_co)
  );

  always #5 clk = ~clk;

  // Reference ALU: arith (A+ci, A+B+ci, A+~B+ci, A-1+ci), logic (AND/OR/XOR/NOT A),
  // shift right with Ir, shift left with IL.
  logic [4:0] sum;
  always_comb begin
    sum    = '0;
    alu_f  = '0;
    alu_co = 1'b0;
    case (alu_sel[3:2])
      2'b00: begin
        case (alu_sel[1:0])
          2'b00: sum = {1'b0, alu_a} + {4'b0, alu_ci};
          2'b01: sum = {1'b0, alu_a} + {1'b0, alu_b} + {4'b0, alu_ci};
          2'b10: sum = {1'b0, alu_a} + {1'b0, ~alu_b} + {4'b0, alu_ci};
          default: sum = {1'b0, alu_a} + 5'h0F + {4'b0, alu_ci};
        endcase
        alu_f  = sum[3:0];
        alu_co = sum[4];
      end
      2'b01: begin
        case (alu_sel[1:0])
          2'b00: alu_f = alu_a & alu_b;
          2'b01: alu_f = alu_a | alu_b;
          2'b10: alu_f = alu_a ^ alu_b;
          default: alu_f = ~alu_a;
        endcase
      end
      2'b10: begin
        alu_f  = {alu_ir, alu_a[3:1]};
        alu_co = alu_a[0];
      end
      default: begin
        alu_f  = {alu_a[2:0], alu_il};
        alu_co = alu_a[3];
      end
    endcase
  end

  typedef struct {
    logic [1:0] typ;
    logic [3:0] sel;
    logic       ci;
    logic [1:0] src;
    logic [1:0] dst;
    logic [3:0] imm;
    logic [1:0] cnt;
    logic [3:0] exp_data;
    logic [2:0] exp_flags;
    int         exp_lat;
  } vec_t;

  vec_t vecs[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic vec_t mkv(input logic [1:0] typ, input logic [3:0] sel, input logic ci,
                               input logic [1:0] src, input logic [1:0] dst, input logic [3:0] imm,
                               input logic [1:0] cnt, input logic [3:0] d, input logic [2:0] f,
                               input int lat);
    vec_t v;
    v.typ = typ; v.sel = sel; v.ci = ci; v.src = src; v.dst = dst; v.imm = imm;
    v.cnt = cnt; v.exp_data = d; v.exp_flags = f; v.exp_lat = lat;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drives one command and returns just after its accept edge.
  task automatic issue(input logic [1:0] typ, input logic [3:0] sel, input logic ci,
                       input logic [1:0] src, input logic [1:0] dst, input logic [3:0] imm,
                       input logic [1:0] cnt);
    @(negedge clk);
    bus.cmd_type = typ; bus.cmd_sel = sel; bus.cmd_ci = ci; bus.cmd_src = src;
    bus.cmd_dst = dst; bus.cmd_imm = imm; bus.cmd_cnt = cnt; bus.cmd_valid = 1'b1;
    chk("cmd_ready_before_accept", bus.cmd_ready, 1'b1);
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
  endtask

  // Cycle index (accept cycle T is 0) at which res_valid is first seen; 0 on timeout.
  task automatic wait_result(output int cyc);
    cyc = 0;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      if (bus.res_valid) begin
        cyc = k + 1;
        break;
      end
    end
  endtask

  task automatic release_result();
    @(negedge clk);
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1 bus.res_ready = 1'b0;
    chk("idle_after_release", {bus.cmd_ready, bus.res_valid}, 2'b10);
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    int   cyc;
    v = vecs[idx];
    issue(v.typ, v.sel, v.ci, v.src, v.dst, v.imm, v.cnt);
    wait_result(cyc);
    if (cyc == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL vec%0d_timeout: res_valid never rose, expected at cycle %0d", idx, v.exp_lat);
    end else begin
      chk($sformatf("vec%0d_latency", idx), cyc, v.exp_lat);
      chk($sformatf("vec%0d_data", idx), bus.res_data, v.exp_data);
      chk($sformatf("vec%0d_flags", idx), bus.res_flags, v.exp_flags);
      chk($sformatf("vec%0d_ready_low", idx), bus.cmd_ready, 1'b0);
    end
    release_result();
  endtask

  initial begin
    int cyc;
    logic [3:0] held;
    logic saw_result;

    // typ: 0 ALU, 1 LDR, 2 LDA, 3 STA; flags are {C,Z,N}
    vecs.push_back(mkv(2'd1, 4'h0, 1'b0, 2'd0, 2'd0, 4'h5, 2'd0, 4'h5, 3'b000, 1)); // 0 LDR R0<-5
    vecs.push_back(mkv(2'd1, 4'h0, 1'b0, 2'd0, 2'd1, 4'h3, 2'd0, 4'h3, 3'b000, 1)); // 1 LDR R1<-3
    vecs.push_back(mkv(2'd2, 4'h0, 1'b0, 2'd0, 2'd0, 4'h0, 2'd0, 4'h5, 3'b000, 1)); // 2 LDA R0
    vecs.push_back(mkv(2'd0, 4'h1, 1'b0, 2'd1, 2'd0, 4'h0, 2'd0, 4'h8, 3'b001, 2)); // 3 5+3
    vecs.push_back(mkv(2'd2, 4'h0, 1'b0, 2'd0, 2'd0, 4'h0, 2'd0, 4'h5, 3'b001, 1)); // 4 LDA R0
    vecs.push_back(mkv(2'd0, 4'h2, 1'b1, 2'd1, 2'd0, 4'h0, 2'd0, 4'h2, 3'b100, 2)); // 5 5-3
    vecs.push_back(mkv(2'd1, 4'h0, 1'b0, 2'd0, 2'd2, 4'h5, 2'd0, 4'h5, 3'b100, 1)); // 6 LDR R2<-5
    vecs.push_back(mkv(2'd2, 4'h0, 1'b0, 2'd2, 2'd0, 4'h0, 2'd0, 4'h5, 3'b100, 1)); // 7 LDA R2
    vecs.push_back(mkv(2'd0, 4'h4, 1'b0, 2'd2, 2'd0, 4'h0, 2'd0, 4'h5, 3'b000, 2)); // 8 5&5 clears C
    vecs.push_back(mkv(2'd1, 4'h0, 1'b0, 2'd0, 2'd0, 4'h3, 2'd0, 4'h3, 3'b100, 1)); // 9 LDR R0<-3
    vecs.push_back(mkv(2'd2, 4'h0, 1'b0, 2'd0, 2'd0, 4'h0, 2'd0, 4'h3, 3'b100, 1)); // 10 LDA R0
    vecs.push_back(mkv(2'd1, 4'h0, 1'b0, 2'd0, 2'd2, 4'hC, 2'd0, 4'hC, 3'b100, 1)); // 11 LDR R2<-C
    vecs.push_back(mkv(2'd0, 4'h4, 1'b0, 2'd2, 2'd0, 4'h0, 2'd0, 4'h0, 3'b010, 2)); // 12 3&C=0
    vecs.push_back(mkv(2'd3, 4'h0, 1'b0, 2'd0, 2'd3, 4'h0, 2'd0, 4'h0, 3'b010, 1)); // 13 STA R3
    vecs.push_back(mkv(2'd2, 4'h0, 1'b0, 2'd3, 2'd0, 4'h0, 2'd0, 4'h0, 3'b010, 1)); // 14 LDA R3
    vecs.push_back(mkv(2'd1, 4'h0, 1'b0, 2'd0, 2'd1, 4'h9, 2'd0, 4'h9, 3'b010, 1)); // 15 LDR R1<-9
    vecs.push_back(mkv(2'd2, 4'h0, 1'b0, 2'd1, 2'd0, 4'h0, 2'd0, 4'h9, 3'b010, 1)); // 16 LDA R1
    vecs.push_back(mkv(2'd0, 4'h8, 1'b0, 2'd0, 2'd0, 4'h0, 2'd0, 4'h4, 3'b100, 2)); // 17 SHR once
    vecs.push_back(mkv(2'd0, 4'h8, 1'b0, 2'd0, 2'd0, 4'h0, 2'd3, 4'h9, 3'b001, 5)); // 18 SHR x4 via C
    vecs.push_back(mkv(2'd3, 4'h0, 1'b0, 2'd0, 2'd0, 4'h0, 2'd0, 4'h9, 3'b001, 1)); // 19 STA R0

    bus.cmd_valid = 1'b0; bus.cmd_type = '0; bus.cmd_sel = '0; bus.cmd_ci = 1'b0;
    bus.cmd_src = '0; bus.cmd_dst = '0; bus.cmd_imm = '0; bus.cmd_cnt = '0; bus.res_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready_valid", {bus.cmd_ready, bus.res_valid}, 2'b10);
    chk("reset_sel_ci", {alu_sel, alu_ci}, 5'b0);
    chk("reset_ac", alu_a, 4'h0);
    chk("reset_flags", bus.res_flags, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i <= 8; i++) run_vec(i);

    // Rotate left through carry twice: 0101,C0 -> 1010,C0 -> 0100,C1
    issue(2'd0, 4'hC, 1'b0, 2'd0, 2'd0, 4'h0, 2'd1);
    chk("rot_iter1_ac", alu_a, 4'h5);
    chk("rot_iter1_valid", bus.res_valid, 1'b0);
    @(posedge clk);
    #1;
    chk("rot_iter2_ac", alu_a, 4'hA);
    chk("rot_iter2_carry", alu_ir, 1'b0);
    chk("rot_iter2_valid", bus.res_valid, 1'b0);
    @(posedge clk);
    #1;
    chk("rot_valid_cycle3", bus.res_valid, 1'b1);
    chk("rot_data", bus.res_data, 4'h4);
    chk("rot_flags", bus.res_flags, 3'b100);
    release_result();

    for (int i = 9; i < vecs.size(); i++) run_vec(i);

    // Backpressure with a stray command pulse that must be ignored
    issue(2'd1, 4'h0, 1'b0, 2'd0, 2'd2, 4'h7, 2'd0);
    wait_result(cyc);
    chk("bp_latency", cyc, 1);
    held = bus.res_data;
    chk("bp_data", held, 4'h7);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.cmd_valid = (k == 1);
      bus.cmd_type = 2'd1; bus.cmd_dst = 2'd1; bus.cmd_imm = 4'hF;
      chk($sformatf("bp_hold%0d", k), {bus.res_valid, bus.cmd_ready, bus.res_data},
          {1'b1, 1'b0, 4'h7});
    end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    chk("bp_flags", bus.res_flags, 3'b001);
    release_result();
    run_vec_lda1: begin
      issue(2'd2, 4'h0, 1'b0, 2'd1, 2'd0, 4'h0, 2'd0);
      wait_result(cyc);
      chk("bp_ignored_cmd_latency", cyc, 1);
      chk("bp_ignored_cmd_r1", bus.res_data, 4'h9);
      release_result();
    end

    // Reset during the second EXEC cycle of a 4-iteration shift
    issue(2'd0, 4'hC, 1'b0, 2'd0, 2'd0, 4'h0, 2'd3);
    chk("rst_exec1_ac", alu_a, 4'h9);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_ac", alu_a, 4'h0);
    chk("rst_mid_flags", bus.res_flags, 3'b000);
    chk("rst_mid_hs", {bus.cmd_ready, bus.res_valid}, 2'b10);
    chk("rst_mid_sel_ci", {alu_sel, alu_ci}, 5'b0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_result = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.res_valid || !bus.cmd_ready) saw_result = 1'b1;
    end
    chk("rst_no_result", saw_result, 1'b0);
    issue(2'd2, 4'h0, 1'b0, 2'd0, 2'd0, 4'h0, 2'd0);
    wait_result(cyc);
    chk("rst_regs_cleared_lat", cyc, 1);
    chk("rst_regs_cleared", {bus.res_data, bus.res_flags}, 7'b0);
    release_result();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_acc_sequencer.md
# alu_acc_sequencer

Control and storage stage directly upstream of the 4-bit arithmetic logic shift unit.

- Accepts commands over a valid/ready handshake.
- Holds a 4-bit accumulator (AC), four 4-bit general registers (R0–R3) and status flags C/Z/N.
- Drives the combinational ALU's `Sel/A/B/Ci/Ir/IL` inputs and captures `F/Co` back into AC and the flags.
- Supports repeated execution, e.g. multi-bit shifts or rotates through carry, and returns a result with backpressure.

## Interface

Parameters:
- `NREG`, 4: number of general registers. Must be 4, since the index fields are 2 bits.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  block can accept a command. High only in IDLE.
- `cmd_type`  in  2  command type: 00 ALU, 01 LDR (R[dst]←imm), 10 LDA (AC←R[src]), 11 STA (R[dst]←AC).
- `cmd_sel`  in  4  ALU function code, passed to `alu_sel`.
- `cmd_ci`  in  1  ALU carry-in.
- `cmd_src`  in  2  source register index; used as B operand or LDA source.
- `cmd_dst`  in  2  destination register index for LDR/STA.
- `cmd_imm`  in  4  immediate for LDR.
- `cmd_cnt`  in  2  repeat count. An ALU op executes `cmd_cnt+1` times.
- `alu_sel`  out  4  to ALU `Sel` (registered).
- `alu_a`  out  4  to ALU `A`; equals AC.
- `alu_b`  out  4  to ALU `B`; equals R[latched src].
- `alu_ci`  out  1  to ALU `Ci` (registered).
- `alu_ir`  out  1  to ALU `Ir`; equals flag C.
- `alu_il`  out  1  to ALU `IL`; equals flag C.
- `alu_f`  in  4  from ALU `F`.
- `alu_co`  in  1  from ALU `Co`.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer accepts the result.
- `res_data`  out  4  result value.
- `res_flags`  out  3  {C,Z,N} after the command.

## Operation

- States: IDLE, EXEC, DONE.
- IDLE: `cmd_ready`=1. On `cmd_valid`&`cmd_ready`, latch all command fields.
  - ALU commands: load iteration counter ← `cmd_cnt`, go to EXEC.
  - LDR/LDA/STA: perform the write on the accept edge, then go to DONE.
- EXEC, each cycle: ALU inputs are stable. On the clock edge, AC ← `alu_f` and flags update.
  - Counter nonzero: decrement, stay in EXEC. Next iteration uses the new AC and C.
  - Counter zero: go to DONE.
- Flag update per ALU iteration, by `sel[3:2]`:
  - 00 (arithmetic): C ← `alu_co`.
  - 01 (logic): C ← 0.
  - 10 (shift right): C ← AC[0].
  - 11 (shift left): C ← AC[3].
  - All cases: Z ← (`alu_f`==0), N ← `alu_f[3]`.
  - Feeding C into `Ir`/`IL` gives a 5-bit rotate through carry.
- Non-ALU commands leave C/Z/N unchanged.
- `res_data` by command type:
  - ALU, LDA: AC.
  - LDR: imm.
  - STA: AC (the value written).
- DONE: `res_valid`=1; `res_data`/`res_flags` held stable. On `res_ready`, go to IDLE.
- `alu_sel` and `alu_ci` hold the last latched values outside EXEC.
- Reset, at any time including mid-EXEC:
  - State IDLE; AC, R0–R3, C, Z, N = 0.
  - `alu_sel`=0, `alu_ci`=0, `res_valid`=0, `cmd_ready`=1.
  - The aborted command produces no result.

## Timing

- Command accepted at edge T:
  - ALU op: EXEC spans cycles T+1 … T+1+cnt; `res_valid` rises at T+2+cnt.
  - LDR/LDA/STA: `res_valid` at T+1.
- Throughput: one command per (latency+1) cycles when `res_ready`=1. There is no accept in DONE.
- `cmd_ready` is low from the accept edge until the DONE→IDLE edge.
- `res_valid` stays high and outputs stay unchanged while `res_ready`=0, for any number of cycles.
- `alu_a`/`alu_b`/`alu_ir`/`alu_il` are combinational from registers. `alu_f`/`alu_co` are sampled in the same cycle (ALU is combinational).
- `cmd_*` inputs are don't-care outside the accept cycle.

## Test plan

- Load and add: LDR R0←5, LDR R1←3, LDA R0, then ALU sel=0001 ci=0 src=R1 cnt=0. Required: `res_data`=1000, flags C=0 Z=0 N=1; `res_valid` 2 cycles after accept.
- Subtract: AC=5, ALU sel=0010 ci=1 src=R1. Required: `res_data`=0010, C=1, Z=0, N=0.
- Rotate through carry: AC=0101, C=0, ALU sel=1100 cnt=1. Required: two EXEC cycles; after the first iteration AC=1010, C=0; final AC=0100, C=1. `res_valid` 3 cycles after accept.
- Backpressure: hold `res_ready`=0 for 3 cycles in DONE. Required: `res_valid`=1 and `res_data` constant throughout; `cmd_ready`=0; a `cmd_valid` pulse is ignored; IDLE is reached one edge after `res_ready`=1.
- Zero/logic: AC=0011, R2=1100, ALU sel=0100 (AND) src=R2. Required: `res_data`=0000, Z=1, C=0, N=0. Then STA R3, LDA R3 gives `res_data`=0000.
- Reset mid-EXEC: issue cnt=3 shift, assert `rst_n`=0 during the second EXEC cycle. Required: immediately AC=0, flags=0, `res_valid`=0, `cmd_ready`=1; no result after release.
